// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, idle line level and data width.
// Used by both the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLK_PER_BIT-1 while clr is low and pulses tick
// on the wrap cycle. Held at zero while clr is high. Shared by TX and RX.
module uart_bit_timer #(
  parameter int CLK_PER_BIT = 50,
  parameter int CTR_W       = $clog2(CLK_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CTR_W-1:0] CNT_MAX = CTR_W'(CLK_PER_BIT - 1);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  // Next count: clear, wrap with tick, or increment.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_tx_engine.sv
// UART transmitter, 8N1, LSB first. Accepts a byte on the new_tx_data strobe
// when idle and not blocked, and serializes it onto a registered tx line.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit before stop.
module serial_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 50,
  parameter int CTR_W       = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  input  logic       block,
  output logic       tx_busy,
  output logic       tx
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        block_q, block_d;
  logic        accept;
  logic        tick;
  logic        timer_clr;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  // The timer runs only while a frame is in flight, so every bit starts at count 0.
  assign timer_clr = (state_q == ST_IDLE);

  uart_bit_timer #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .CTR_W       (CTR_W)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .tick (tick)
  );

  // Next-state, shift register, bit index and registered line level.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    block_d   = block;
    tx_d      = UART_IDLE_LVL;
    // block_q gates the accept, so a strobe in the cycle block rises still goes through.
    accept    = (state_q == ST_IDLE) && !busy_q && !block_q && new_tx_data;
`ifdef UART_TX_PARITY_EN
    parity_d  = accept ? ^tx_data : parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          shift_d   = tx_data;
          bit_idx_d = '0;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered from the level of the state being entered.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = UART_IDLE_LVL;
    endcase

    // Busy rises with block_q, i.e. one cycle after block.
    busy_d = (state_d != ST_IDLE) | block_d;
  end

  // Control and datapath registers, all cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= UART_IDLE_LVL;
      busy_q    <= 1'b0;
      block_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      block_q   <= block_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the accepted byte, captured before the shift register consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
`endif

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_serial_tx_engine.sv
// Bench for serial_tx_engine: cycle-level waveform model plus a UART decoder.
module tb_serial_tx_engine;

`ifdef UART_TX_PARITY_EN
  localparam int CPB   = 50;
  localparam int NBITS = 11;
`else
  localparam int CPB   = 4;
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       block;
  logic       tx_busy;
  logic       tx;

  always #5 clk = ~clk;

  serial_tx_engine #(.CLK_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .block       (block),
    .tx_busy     (tx_busy),
    .tx          (tx)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected line level per future cycle, built from the frame rules.
  logic       exp_line[$];
  logic [7:0] sent_q[$];
  logic       m_tx   = 1'b1;
  logic       m_busy = 1'b0;

  task automatic load_frame(input logic [7:0] d);
    logic lvl[$];
    lvl.push_back(1'b0);
    for (int i = 0; i < 8; i++) lvl.push_back(d[i]);
    if (NBITS == 11) lvl.push_back(^d);
    lvl.push_back(1'b1);
    foreach (lvl[k]) for (int c = 0; c < CPB; c++) exp_line.push_back(lvl[k]);
  endtask

  // One clock: advance the model at the rising edge, compare at the falling edge.
  task automatic cycle();
    logic active;
    @(posedge clk);
    if (rst) begin
      if (exp_line.size() > 0) void'(sent_q.pop_back());
      exp_line.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      if (new_tx_data && !m_busy) begin
        load_frame(tx_data);
        sent_q.push_back(tx_data);
      end
      if (exp_line.size() > 0) begin
        m_tx   = exp_line.pop_front();
        active = 1'b1;
      end else begin
        m_tx   = 1'b1;
        active = 1'b0;
      end
      m_busy = active | block;
    end
    @(negedge clk);
    check("tx", tx, m_tx);
    check("tx_busy", tx_busy, m_busy);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [7:0] d);
    tx_data     = d;
    new_tx_data = 1'b1;
    cycle();
    new_tx_data = 1'b0;
  endtask

  // Independent UART decoder on the DUT line, sampling mid-bit.
  logic [7:0] dec_q[$];
  logic [7:0] dec_byte;
  logic       dec_act;
  int         dec_cnt;
  int         dec_idx;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      dec_act = 1'b0;
      dec_cnt = 0;
    end else if (!dec_act) begin
      if (tx === 1'b0) begin
        dec_act = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % CPB == CPB / 2) begin
        dec_idx = dec_cnt / CPB;
        if (dec_idx >= 1 && dec_idx <= 8) begin
          dec_byte[dec_idx-1] = tx;
        end else if (dec_idx == NBITS - 1) begin
          check("stop_bit", tx, 1'b1);
          dec_q.push_back(dec_byte);
          dec_act = 1'b0;
        end else if (dec_idx == 9) begin
          check("parity_bit", tx, ^dec_byte);
        end
      end
    end
  end

  int n0;
  int busy_cnt;
  int waited;

  initial begin
    rst         = 1'b1;
    tx_data     = 8'h00;
    new_tx_data = 1'b0;
    block       = 1'b0;
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // Single byte: frame length and busy window.
    send(8'h31);
    busy_cnt = int'(tx_busy);
    repeat (FRAME) begin
      cycle();
      busy_cnt += int'(tx_busy);
    end
    check("busy_window", busy_cnt, FRAME);
    check("busy_low_after_frame", tx_busy, 1'b0);
    idle(2);
    check("byte_31", dec_q.size() > 0 ? dec_q[dec_q.size()-1] : 8'hxx, 8'h31);

    // Strobe during busy is dropped.
    n0 = dec_q.size();
    send(8'h31);
    idle(3 * CPB);
    send(8'hAA);
    idle(FRAME);
    check("drop_frame_count", dec_q.size() - n0, 1);

    // Back-to-back: second strobe on the cycle tx_busy falls.
    n0 = dec_q.size();
    send(8'h30);
    waited = 0;
    while (tx_busy && waited < 2 * FRAME) begin
      cycle();
      waited++;
    end
    check("busy_fall_timeout", tx_busy, 1'b0);
    check("gap_idle_high", tx, 1'b1);
    send(8'h31);
    check("gap_start_next", tx, 1'b0);
    idle(FRAME + 2);
    check("b2b_frame_count", dec_q.size() - n0, 2);

    // Block before the strobe: nothing sent.
    n0 = dec_q.size();
    block = 1'b1;
    cycle();
    send(8'h55);
    idle(FRAME);
    check("blocked_busy", tx_busy, 1'b1);
    check("blocked_no_frame", dec_q.size() - n0, 0);
    block = 1'b0;
    cycle();
    send(8'h55);
    idle(3 * CPB);
    block = 1'b1;              // mid-frame: frame must still complete
    idle(FRAME);
    block = 1'b0;
    idle(3);
    check("block_mid_frame", dec_q.size() - n0, 1);

    // Strobe in the same cycle block rises is accepted.
    n0 = dec_q.size();
    block = 1'b1;
    send(8'hC3);
    block = 1'b0;
    idle(FRAME + 2);
    check("block_rise_accept", dec_q.size() - n0, 1);

    // Async reset during data bit 3.
    n0 = dec_q.size();
    send(8'hA5);
    idle(4 * CPB);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", tx_busy, 1'b0);
    cycle();
    rst = 1'b0;
    send(8'h0F);
    idle(FRAME + 2);
    check("after_rst_frames", dec_q.size() - n0, 1);

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    idle(9 * CPB + CPB / 2);
    check("parity_07", tx, 1'b1);
    idle(FRAME);
`endif

    // Randomized traffic with occasional block toggles.
    for (int i = 0; i < 60 * CPB; i++) begin
      if ($urandom_range(0, 15) == 0) block = ~block;
      tx_data     = 8'($urandom);
      new_tx_data = ($urandom_range(0, 3) == 0);
      cycle();
    end
    new_tx_data = 1'b0;
    block       = 1'b0;
    idle(FRAME + 4);

    check("frame_total", dec_q.size(), sent_q.size());
    for (int i = 0; i < dec_q.size() && i < sent_q.size(); i++)
      check("frame_byte", dec_q[i], sent_q[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
